// File: rtl/stream_packer_pkg.sv
// Shared stream-packer definitions: default lane geometry, the exclusive prefix
// popcount helper, and the per-lane tuple type used by the sw2 wiring.
package stream_packer_pkg;

    localparam int unsigned DEF_NLANES = 4;
    localparam int unsigned DEF_DWIDTH = 8;
    localparam int unsigned DEF_AWIDTH = $clog2(DEF_NLANES);
    // Widest keep vector popcount_below accepts; callers zero-extend into it.
    localparam int unsigned MAX_LANES  = 64;

    typedef struct packed {
        logic [DEF_DWIDTH-1:0] data;
        logic [DEF_AWIDTH-1:0] dst;
        logic                  vld;
    } lane_t;

    // Number of set bits in keep[idx-1:0]; zero for idx == 0.
    function automatic int unsigned popcount_below(input logic [MAX_LANES-1:0] keep,
                                                   input int unsigned idx);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < idx && keep[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prefix_count.sv
// Combinational exclusive prefix popcount: per-lane rank of each lane among the
// kept lanes below it, plus the total number of kept lanes.
module prefix_count
    import stream_packer_pkg::*;
#(
    parameter int unsigned NLANES = 4,
    localparam int unsigned AWIDTH = $clog2(NLANES)
) (
    input  logic [NLANES-1:0]        keep,
    output logic [NLANES*AWIDTH-1:0] rank,
    output logic [AWIDTH:0]          total
);

    logic [MAX_LANES-1:0] keep_ext;

    always_comb begin
        keep_ext = MAX_LANES'(keep);
        rank     = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            rank[i*AWIDTH +: AWIDTH] = AWIDTH'(popcount_below(keep_ext, i));
        end
        total = (AWIDTH+1)'(popcount_below(keep_ext, NLANES));
    end

endmodule

// File: rtl/banyan_dst_gen.sv
// Banyan destination generator: assigns each kept lane a cyclic output lane from a
// running fill pointer. Define STREAM_PACKER_DSTGEN_STATS_EN to add beat/element counters.
module banyan_dst_gen
    import stream_packer_pkg::*;
#(
    parameter int unsigned NLANES = 4,
    parameter int unsigned DWIDTH = 8,
    localparam int unsigned AWIDTH = $clog2(NLANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NLANES*DWIDTH-1:0] in_data,
    input  logic [NLANES-1:0]        in_keep,
    input  logic                     in_last,
    input  logic                     in_vld,
    output logic [NLANES*DWIDTH-1:0] out_data,
    output logic [NLANES*AWIDTH-1:0] out_dst,
    output logic [NLANES-1:0]        out_vld,
    output logic                     out_beat,
    output logic                     out_word_done,
    output logic                     out_last,
`ifdef STREAM_PACKER_DSTGEN_STATS_EN
    output logic [31:0]              stat_beats,
    output logic [31:0]              stat_elems,
`endif
    output logic [AWIDTH-1:0]        out_fill
);

    logic [NLANES*AWIDTH-1:0] rank;
    logic [AWIDTH:0]          total;
    logic [AWIDTH:0]          sum;
    logic [AWIDTH-1:0]        base_q, base_d;
    logic [NLANES*AWIDTH-1:0] dst_d;

    logic [NLANES*DWIDTH-1:0] data_q;
    logic [NLANES*AWIDTH-1:0] dst_q;
    logic [NLANES-1:0]        vld_q;
    logic                     beat_q, word_done_q, last_q;

    prefix_count #(
        .NLANES(NLANES)
    ) u_prefix_count (
        .keep (in_keep),
        .rank (rank),
        .total(total)
    );

    always_comb begin
        sum   = {1'b0, base_q} + total;
        dst_d = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (in_keep[i]) begin
                // AWIDTH-bit add wraps naturally modulo NLANES.
                dst_d[i*AWIDTH +: AWIDTH] = base_q + rank[i*AWIDTH +: AWIDTH];
            end
        end
        base_d = base_q;
        if (in_vld) begin
            base_d = in_last ? '0 : sum[AWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            data_q      <= '0;
            dst_q       <= '0;
            vld_q       <= '0;
            beat_q      <= 1'b0;
            word_done_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            base_q      <= base_d;
            beat_q      <= in_vld;
            vld_q       <= in_vld ? in_keep : '0;
            word_done_q <= in_vld & sum[AWIDTH];
            last_q      <= in_vld & in_last;
            if (in_vld) begin
                data_q <= in_data;
                dst_q  <= dst_d;
            end
        end
    end

    assign out_data      = data_q;
    assign out_dst       = dst_q;
    assign out_vld       = vld_q;
    assign out_beat      = beat_q;
    assign out_word_done = word_done_q;
    assign out_last      = last_q;
    assign out_fill      = base_q;

`ifdef STREAM_PACKER_DSTGEN_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_elems_q, stat_elems_d;
    logic [32:0] elems_sum;

    always_comb begin
        elems_sum    = {1'b0, stat_elems_q} + 33'(total);
        stat_beats_d = stat_beats_q;
        stat_elems_d = stat_elems_q;
        if (in_vld) begin
            if (stat_beats_q != '1) begin
                stat_beats_d = stat_beats_q + 32'd1;
            end
            stat_elems_d = elems_sum[32] ? '1 : elems_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats_q <= '0;
            stat_elems_q <= '0;
        end else begin
            stat_beats_q <= stat_beats_d;
            stat_elems_q <= stat_elems_d;
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_elems = stat_elems_q;
`endif

endmodule

// File: tb/tb_banyan_dst_gen.sv
// Self-checking bench for banyan_dst_gen: behavioural fill-pointer model compared every
// cycle, directed literal checks, a keep x base sweep and randomized traffic.
module tb_banyan_dst_gen;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NL*DW-1:0] in_data = '0;
    logic [NL-1:0]    in_keep = '0;
    logic             in_last = 1'b0;
    logic             in_vld  = 1'b0;
    logic [NL*DW-1:0] out_data;
    logic [NL*AW-1:0] out_dst;
    logic [NL-1:0]    out_vld;
    logic             out_beat, out_word_done, out_last;
    logic [AW-1:0]    out_fill;
`ifdef STREAM_PACKER_DSTGEN_STATS_EN
    logic [31:0]      stat_beats, stat_elems;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    banyan_dst_gen #(
        .NLANES(NL),
        .DWIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_keep      (in_keep),
        .in_last      (in_last),
        .in_vld       (in_vld),
        .out_data     (out_data),
        .out_dst      (out_dst),
        .out_vld      (out_vld),
        .out_beat     (out_beat),
        .out_word_done(out_word_done),
        .out_last     (out_last),
`ifdef STREAM_PACKER_DSTGEN_STATS_EN
        .stat_beats   (stat_beats),
        .stat_elems   (stat_elems),
`endif
        .out_fill     (out_fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the registered outputs must show after each edge.
    bit               chk_en = 1'b0;
    int               m_base = 0;
    logic [NL*DW-1:0] exp_data;
    logic [NL*AW-1:0] exp_dst;
    logic [NL-1:0]    exp_vld;
    logic             exp_beat, exp_wd, exp_last;
    logic [AW-1:0]    exp_fill;
    longint           m_beats = 0;
    longint           m_elems = 0;

    always @(posedge clk) begin : model
        int k;
        chk_en = 1'b1;
        if (rst) begin
            m_base = 0;
            exp_data = '0; exp_dst = '0; exp_vld = '0;
            exp_beat = 0; exp_wd = 0; exp_last = 0; exp_fill = '0;
            m_beats = 0; m_elems = 0;
        end else if (in_vld) begin
            k = 0;
            exp_dst = '0;
            for (int i = 0; i < NL; i++) begin
                if (in_keep[i]) begin
                    exp_dst[i*AW +: AW] = AW'((m_base + k) % NL);
                    k++;
                end
            end
            exp_wd   = (m_base + k) >= NL;
            m_base   = in_last ? 0 : (m_base + k) % NL;
            exp_fill = AW'(m_base);
            exp_beat = 1; exp_vld = in_keep; exp_last = in_last; exp_data = in_data;
            m_beats++;
            m_elems += k;
        end else begin
            exp_beat = 0; exp_vld = '0; exp_wd = 0; exp_last = 0;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("beat", 64'(out_beat), 64'(exp_beat));
            check("vld", 64'(out_vld), 64'(exp_vld));
            check("word_done", 64'(out_word_done), 64'(exp_wd));
            check("last", 64'(out_last), 64'(exp_last));
            check("fill", 64'(out_fill), 64'(exp_fill));
            if (exp_beat || rst) begin
                check("data", 64'(out_data), 64'(exp_data));
                check("dst", 64'(out_dst), 64'(exp_dst));
            end
`ifdef STREAM_PACKER_DSTGEN_STATS_EN
            check("stat_beats", 64'(stat_beats), 64'(m_beats));
            check("stat_elems", 64'(stat_elems), 64'(m_elems));
`endif
        end
    end

    task automatic step(input logic vld, input logic [NL-1:0] keep, input logic last);
        @(negedge clk);
        in_vld  = vld;
        in_keep = keep;
        in_last = last;
        in_data = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b1);
        check("rst_beat", 64'(out_beat), 64'd0);
        check("rst_fill", 64'(out_fill), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 4'b1011, 1'b0);
        check("t1_dst", 64'(out_dst), 64'h84);
        check("t1_vld", 64'(out_vld), 64'hB);
        check("t1_fill", 64'(out_fill), 64'd3);
        check("t1_wd", 64'(out_word_done), 64'd0);

        step(1'b1, 4'b0111, 1'b0);
        check("t2_dst", 64'(out_dst), 64'h13);
        check("t2_fill", 64'(out_fill), 64'd2);
        check("t2_wd", 64'(out_word_done), 64'd1);

        step(1'b1, 4'b1111, 1'b0);
        check("t3_dst", 64'(out_dst), 64'h4E);
        check("t3_fill", 64'(out_fill), 64'd2);
        check("t3_wd", 64'(out_word_done), 64'd1);

        step(1'b1, 4'b0000, 1'b1);
        check("t4_beat", 64'(out_beat), 64'd1);
        check("t4_vld", 64'(out_vld), 64'd0);
        check("t4_last", 64'(out_last), 64'd1);
        check("t4_fill", 64'(out_fill), 64'd0);
        check("t4_wd", 64'(out_word_done), 64'd0);

        step(1'b1, 4'b0011, 1'b0);
        check("t5_dst", 64'(out_dst), 64'h04);
        step(1'b1, 4'b0001, 1'b0);
        check("t6_dst", 64'(out_dst), 64'h02);
        check("t6_fill", 64'(out_fill), 64'd3);

        // Reset mid-packet at base 3 discards the partial word.
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4'b1111, 1'b0);
        check("t7_beat", 64'(out_beat), 64'd0);
        check("t7_vld", 64'(out_vld), 64'd0);
        check("t7_wd", 64'(out_word_done), 64'd0);
        check("t7_last", 64'(out_last), 64'd0);
        check("t7_fill", 64'(out_fill), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'b0001, 1'b0);
        check("t8_dst0", 64'(out_dst[AW-1:0]), 64'd0);
        check("t8_fill", 64'(out_fill), 64'd1);

        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'(c + 5), 1'b1);
            check("idle_beat", 64'(out_beat), 64'd0);
            check("idle_vld", 64'(out_vld), 64'd0);
            check("idle_fill", 64'(out_fill), 64'd1);
        end

        // Every keep pattern from every base; model does the checking.
        for (int b = 0; b < NL; b++) begin
            for (int kp = 0; kp < 16; kp++) begin
                step(1'b1, 4'b0000, 1'b1);
                if (b != 0) step(1'b1, 4'((1 << b) - 1), 1'b0);
                step(1'b1, 4'(kp), 1'(kp & 1));
            end
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                step(1'($urandom), 4'($urandom), 1'($urandom));
                @(negedge clk);
                rst = 1'b0;
            end
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        in_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
